// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types and widths for the digital-to-time converter
package dtc_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, PULSE} dtc_state_t;
  localparam int CODE_W = 4;
  localparam int CODE_MIN = -8;
  localparam int CODE_MAX = 7;
  localparam int CNT_W = 5;
  typedef logic signed [CODE_W-1:0] dtc_code_t;
endpackage

// File: rtl/dtc_code_fifo.sv
// dtc_code_fifo: 2-entry synchronous FIFO holding pending timing codes
module dtc_code_fifo
  import dtc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  logic [CODE_W-1:0] mem [2];
  logic              wp, rp;
  logic [1:0]        cnt;
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout  = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= !wp;
      end
      if (pop) rp <= !rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/dtc_counter.sv
// dtc_counter: regenerates a delayed pulse (code + OFFSET + 1 fine-clock steps) per trigger edge
module dtc_counter
  import dtc_pkg::*;
#(
  parameter int OFFSET  = 8,
  parameter int PULSE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              clk_out,
  output logic              busy,
  output logic              miss
);
  dtc_state_t        state;
  logic [CNT_W-1:0]  cnt, ld;
  logic [2:0]        pw;
  logic [CODE_W-1:0] head;
  logic              trig_d, det, push, pop, full, empty;
  assign det        = trig && !trig_d;
  assign code_ready = !full;
  assign push       = code_valid && code_ready;
  assign pop        = det && state == IDLE && !empty;
  // OFFSET >= 8 keeps the sum non-negative, so the 5-bit wrap is exact
  assign ld         = {head[CODE_W-1], head} + CNT_W'(OFFSET);
  dtc_code_fifo u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (code_in),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pw      <= '0;
      clk_out <= 1'b0;
      busy    <= 1'b0;
      miss    <= 1'b0;
      trig_d  <= 1'b1;
    end else begin
      trig_d <= trig;
      miss   <= det && (state != IDLE || empty);
      case (state)
        IDLE: if (pop) begin
          busy <= 1'b1;
          if (ld == '0) begin
            clk_out <= 1'b1;
            pw      <= 3'(PULSE_W - 1);
            state   <= PULSE;
          end else begin
            cnt   <= ld - 1'b1;
            state <= COUNT;
          end
        end
        COUNT: if (cnt == '0) begin
          clk_out <= 1'b1;
          pw      <= 3'(PULSE_W - 1);
          state   <= PULSE;
        end else cnt <= cnt - 1'b1;
        PULSE: if (pw == '0) begin
          clk_out <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end else pw <= pw - 1'b1;
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dtc_counter.sv
// tb_dtc_counter: randomized and directed checks of dtc_counter against a timeline model
module tb_dtc_counter;
  localparam int OFFSET = 8, PW = 2;
  logic       clk = 1'b0, rst = 1'b1, trig = 1'b1, code_valid = 1'b0;
  logic [3:0] code_in = 4'd0;
  logic       code_ready, clk_out, busy, miss;
  int         errors = 0, checks = 0, k = 0, ps = -100, acc = -100;
  int         q[$];
  logic       tp = 1'b1, m_clk = 1'b0, m_busy = 1'b0, m_miss = 1'b0, m_ready = 1'b1;

  always #5 clk = ~clk;

  dtc_counter #(.OFFSET(OFFSET), .PULSE_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .code_in   (code_in),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .clk_out   (clk_out),
    .busy      (busy),
    .miss      (miss)
  );

  // Model: an accepted trigger at edge k with code c owns edges k..ps+PW-1, pulse at ps=k+c+OFFSET
  task automatic step(input logic r, input logic t, input logic v, input logic [3:0] c);
    int   pre;
    logic det, idle;
    rst = r; trig = t; code_valid = v; code_in = c;
    @(posedge clk);
    k++;
    if (r) begin
      q.delete(); tp = 1'b1; ps = -100; acc = -100; m_miss = 1'b0;
    end else begin
      det  = t && !tp;
      tp   = t;
      idle = !(k - 1 >= acc && k - 1 < ps + PW);
      pre  = q.size();
      m_miss = det && !(idle && pre > 0);
      if (det && idle && pre > 0) begin
        acc = k;
        ps  = k + q.pop_front() + OFFSET;
      end
      if (v && pre < 2) q.push_back(int'($signed(c)));
    end
    m_clk   = k >= ps && k < ps + PW;
    m_busy  = k >= acc && k < ps + PW;
    m_ready = q.size() < 2;
    #1;
  endtask

  task automatic test_reset;
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      checks++;
      if ({clk_out, busy, miss, code_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reset k=%0d got out/busy/miss/rdy=%b%b%b%b exp=0001", k, clk_out, busy, miss, code_ready);
      end
    end
  endtask

  task automatic test_basic;
    int d = 0, bh = 0;
    step(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, i == 1, 1'b0, 4'd0);
      if (d == 0 && clk_out === 1'b1) d = i;
      if (busy === 1'b1) bh++;
      checks++;
      if ({clk_out, busy, miss, code_ready} !== {m_clk, m_busy, m_miss, m_ready}) begin
        errors++;
        $display("FAIL basic k=%0d got %b%b%b%b exp %b%b%b%b", k, clk_out, busy, miss, code_ready, m_clk, m_busy, m_miss, m_ready);
      end
    end
    checks++;
    if (d !== OFFSET + 1 || bh !== OFFSET + PW) begin
      errors++;
      $display("FAIL basic_delay got delay=%0d busy=%0d exp delay=%0d busy=%0d", d, bh, OFFSET + 1, OFFSET + PW);
    end
  endtask

  task automatic test_sweep;
    int prev = 0;
    for (int c = -8; c <= 7; c++) begin
      int d = 0;
      step(1'b0, 1'b0, 1'b1, 4'(c));
      for (int i = 1; i <= 22; i++) begin
        step(1'b0, i == 1, 1'b0, 4'd0);
        if (d == 0 && clk_out === 1'b1) d = i;
        checks++;
        if ({clk_out, busy, miss, code_ready} !== {m_clk, m_busy, m_miss, m_ready}) begin
          errors++;
          $display("FAIL sweep c=%0d k=%0d got %b%b%b%b exp %b%b%b%b", c, k, clk_out, busy, miss, code_ready, m_clk, m_busy, m_miss, m_ready);
        end
      end
      checks++;
      if (d !== c + OFFSET + 1 || d <= prev) begin
        errors++;
        $display("FAIL sweep_delay c=%0d got %0d exp %0d (prev %0d)", c, d, c + OFFSET + 1, prev);
      end
      prev = d;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] cs [3];
    for (int j = 0; j < 3; j++) cs[j] = 4'($urandom_range(0, 15));
    step(1'b0, 1'b0, 1'b1, cs[0]);
    step(1'b0, 1'b0, 1'b1, cs[1]);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, cs[2]);
      checks++;
      if (code_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full k=%0d got ready=%b exp 0", k, code_ready);
      end
    end
    for (int j = 0; j < 3; j++) begin
      int d = 0;
      for (int i = 1; i <= 22; i++) begin
        step(1'b0, i == 1, j == 0 && i < 3, cs[2]);
        if (d == 0 && clk_out === 1'b1) d = i;
        checks++;
        if ({clk_out, busy, miss, code_ready} !== {m_clk, m_busy, m_miss, m_ready}) begin
          errors++;
          $display("FAIL b2b k=%0d got %b%b%b%b exp %b%b%b%b", k, clk_out, busy, miss, code_ready, m_clk, m_busy, m_miss, m_ready);
        end
      end
      checks++;
      if (d !== int'($signed(cs[j])) + OFFSET + 1) begin
        errors++;
        $display("FAIL b2b_order j=%0d got %0d exp %0d", j, d, int'($signed(cs[j])) + OFFSET + 1);
      end
      step(1'b0, 1'b0, 1'b0, 4'd0);
    end
  endtask

  task automatic test_miss;
    int d = 0, mc = 0;
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (miss !== 1'b1 || clk_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_empty got miss=%b out=%b busy=%b exp 1 0 0", miss, clk_out, busy);
    end
    step(1'b0, 1'b1, 1'b1, 4'd7);
    checks++;
    if (miss !== 1'b0) begin
      errors++;
      $display("FAIL miss_width got %b exp 0", miss);
    end
    step(1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 22; i++) begin
      step(1'b0, i == 1 || i == 5, 1'b0, 4'd0);
      if (d == 0 && clk_out === 1'b1) d = i;
      if (miss === 1'b1) mc++;
      checks++;
      if ({clk_out, busy, miss, code_ready} !== {m_clk, m_busy, m_miss, m_ready}) begin
        errors++;
        $display("FAIL miss_count k=%0d got %b%b%b%b exp %b%b%b%b", k, clk_out, busy, miss, code_ready, m_clk, m_busy, m_miss, m_ready);
      end
    end
    checks++;
    if (d !== 7 + OFFSET + 1 || mc !== 1) begin
      errors++;
      $display("FAIL miss_timing got delay=%0d misses=%0d exp %0d 1", d, mc, 7 + OFFSET + 1);
    end
  endtask

  task automatic test_reset_pulse;
    step(1'b0, 1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 30 && !m_clk; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (clk_out !== 1'b1) begin
      errors++;
      $display("FAIL rstp_pre got out=%b exp 1", clk_out);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0);
      checks++;
      if ({clk_out, busy, miss, code_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL rstp_abort k=%0d got %b%b%b%b exp 0001", k, clk_out, busy, miss, code_ready);
      end
    end
    step(1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (miss !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstp_empty got miss=%b busy=%b exp 1 0", miss, busy);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0 ? !trig : trig,
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      checks++;
      if ({clk_out, busy, miss, code_ready} !== {m_clk, m_busy, m_miss, m_ready}) begin
        errors++;
        $display("FAIL random k=%0d got %b%b%b%b exp %b%b%b%b", k, clk_out, busy, miss, code_ready, m_clk, m_busy, m_miss, m_ready);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sweep;
    test_back_to_back;
    test_miss;
    test_reset_pulse;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
